// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with registered status flags and a valid/ready
// input handshake. Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL/SHR) complete at
// the accept edge. MUL is an unsigned iterative shift-add taking WIDTH edges.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operation request
//   in_ready   block can accept an operation this cycle (combinational)
//   A, B       operands (shifts use B[SHW-1:0] as the amount)
//   ALUOp      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//              101 SHL, 110 SHR (logical), 111 MUL (unsigned)
//   Result     registered result (low half of the product for MUL)
//   ResultHi   registered high half of the product; 0 for other ops
//   CarryOut   registered carry / borrow / last-bit-shifted-out flag
//   Zero       registered zero flag
//   Negative   registered sign flag
//   Overflow   registered signed-overflow flag (ADD/SUB only)
//   out_valid  one-cycle pulse after an op completes
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int  WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             CarryOut,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow,
    output logic             out_valid
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } state_e;

    state_e state;

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right,
    // the accumulator collects the partial products.
    logic [2*WIDTH-1:0] mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic [2*WIDTH-1:0] mul_acc;
    logic [SHW-1:0]     mul_cnt;
    logic [2*WIDTH-1:0] mul_acc_next;

    assign in_ready     = (state == IDLE) && !rst;
    assign mul_acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    // Single-cycle datapath.
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH-1:0] s_res;
    logic             s_carry;
    logic             s_ovf;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        s_res   = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;

        sh_amt = B[SHW-1:0];
        add_w  = {1'b0, A} + {1'b0, B};
        sub_w  = {1'b0, A} - {1'b0, B};
        // The extra bit on each side catches the last bit shifted out;
        // for a zero shift it stays 0.
        shl_w  = {1'b0, A} << sh_amt;
        shr_w  = {A, 1'b0} >> sh_amt;

        case (op_e'(ALUOp))
            OP_ADD: begin
                s_res   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
                s_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (s_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                s_res   = sub_w[WIDTH-1:0];
                s_carry = sub_w[WIDTH];  // borrow: A < B unsigned
                s_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (s_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: s_res = A & B;
            OP_OR:  s_res = A | B;
            OP_XOR: s_res = A ^ B;
            OP_SHL: begin
                s_res   = shl_w[WIDTH-1:0];
                s_carry = shl_w[WIDTH];
            end
            OP_SHR: begin
                s_res   = shr_w[WIDTH:1];
                s_carry = shr_w[0];
            end
            default: ;  // MUL handled by the sequential datapath
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the multiplier working registers are reset too; cheap here
            // and keeps an aborted MUL from leaving stale partial products.
            state      <= IDLE;
            Result     <= '0;
            ResultHi   <= '0;
            CarryOut   <= 1'b0;
            Zero       <= 1'b0;
            Negative   <= 1'b0;
            Overflow   <= 1'b0;
            out_valid  <= 1'b0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
            mul_cnt    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // in_ready is implied here: state is IDLE and rst is low.
                    if (in_valid) begin
                        if (op_e'(ALUOp) == OP_MUL) begin
                            mul_mcand  <= {{WIDTH{1'b0}}, A};
                            mul_mplier <= B;
                            mul_acc    <= '0;
                            mul_cnt    <= '0;
                            state      <= MUL_RUN;
                        end else begin
                            Result    <= s_res;
                            ResultHi  <= '0;
                            CarryOut  <= s_carry;
                            Overflow  <= s_ovf;
                            Zero      <= (s_res == '0);
                            Negative  <= s_res[WIDTH-1];
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    mul_acc    <= mul_acc_next;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt + 1'b1;
                    // Final iteration: the product is complete in mul_acc_next.
                    if (mul_cnt == SHW'(WIDTH - 1)) begin
                        Result    <= mul_acc_next[WIDTH-1:0];
                        ResultHi  <= mul_acc_next[2*WIDTH-1:WIDTH];
                        CarryOut  <= (mul_acc_next[2*WIDTH-1:WIDTH] != '0);
                        Overflow  <= 1'b0;
                        Zero      <= (mul_acc_next == '0);
                        Negative  <= mul_acc_next[2*WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq. Expected results are computed
// by a reference model when an op is presented and queued; the monitor pops
// and compares on every out_valid pulse. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] SHL = 3'b101;
    localparam logic [2:0] SHR = 3'b110;
    localparam logic [2:0] MUL = 3'b111;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   ALUOp;
    logic [W-1:0] Result;
    logic [W-1:0] ResultHi;
    logic         CarryOut;
    logic         Zero;
    logic         Negative;
    logic         Overflow;
    logic         out_valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp),
        .Result    (Result),
        .ResultHi  (ResultHi),
        .CarryOut  (CarryOut),
        .Zero      (Zero),
        .Negative  (Negative),
        .Overflow  (Overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, written from the flag definitions directly.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        int           s;
        int           sum;
        logic [2*W-1:0] prod;
        e   = '0;
        s   = int'(b) % W;
        sum = int'(a) + int'(b);
        case (op)
            ADD: begin
                e.res = sum[W-1:0];
                e.c   = (sum >= (1 << W));
                e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            SUB: begin
                e.res = a - b;
                e.c   = (a < b);
                e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            AND: e.res = a & b;
            OR:  e.res = a | b;
            XOR: e.res = a ^ b;
            SHL: begin
                e.res = a << s;
                e.c   = (s == 0) ? 1'b0 : a[W-s];
            end
            SHR: begin
                e.res = a >> s;
                e.c   = (s == 0) ? 1'b0 : a[s-1];
            end
            default: begin
                prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = prod[W-1:0];
                e.hi  = prod[2*W-1:W];
                e.c   = (e.hi != '0);
                e.z   = (prod == '0);
                e.n   = e.hi[W-1];
            end
        endcase
        if (op != MUL) begin
            e.z = (e.res == '0);
            e.n = e.res[W-1];
        end
        return e;
    endfunction

    // Present an op at the next falling edge; in_valid is left high so
    // callers can issue back-to-back.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        check("in_ready_at_issue", in_ready, 1);
        A        = a;
        B        = b;
        ALUOp    = op;
        in_valid = 1'b1;
        sb.push_back(model(op, a, b));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("Result",   Result,   e.res);
                check("ResultHi", ResultHi, e.hi);
                check("CarryOut", CarryOut, e.c);
                check("Zero",     Zero,     e.z);
                check("Negative", Negative, e.n);
                check("Overflow", Overflow, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo_cycles;
        int stray;
        int waited;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;

        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        ALUOp    = ADD;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {Result, ResultHi, CarryOut, Zero, Negative, Overflow}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // ADD with one-cycle latency check.
        issue(ADD, 8'h05, 8'h03);
        @(negedge clk);
        in_valid = 1'b0;
        check("add_latency_out_valid", out_valid, 1);
        @(negedge clk);
        check("out_valid_single_pulse", out_valid, 0);

        issue(ADD, 8'hFF, 8'h01);
        idle(2);
        issue(SUB, 8'h04, 8'h08);
        idle(1);
        issue(SUB, 8'h80, 8'h01);
        idle(2);

        // Back-to-back logic ops; issue checks in_ready each cycle.
        issue(AND, 8'hAA, 8'hCC);
        issue(OR,  8'hAA, 8'hCC);
        issue(XOR, 8'hAA, 8'hCC);
        idle(2);

        // Shifts, including s=0 via B=8'h08.
        issue(SHL, 8'h81, 8'h01);
        issue(SHR, 8'h81, 8'h01);
        issue(SHL, 8'h81, 8'h08);
        issue(SHR, 8'hB6, 8'h03);
        idle(2);

        // MUL: in_ready low exactly W cycles, ignored in_valid mid-run.
        issue(MUL, 8'hFF, 8'hFF);
        lo_cycles = 0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (in_ready) break;
            lo_cycles++;
            in_valid = (lo_cycles == 3);
            ALUOp    = ADD;
        end
        in_valid = 1'b0;
        check("mul_busy_cycles", lo_cycles, W);
        check("mul_out_valid_at_done", out_valid, 1);
        idle(1);

        issue(MUL, 8'h00, 8'h37);
        idle(W + 1);
        issue(MUL, 8'h0C, 8'h0B);
        idle(W + 1);

        // Reset three cycles into a MUL: aborted, no out_valid.
        issue(MUL, 8'h12, 8'h34);
        idle(3);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_mul_rst_in_ready", in_ready, 0);
        check("mid_mul_rst_out_valid", out_valid, 0);
        check("mid_mul_rst_outputs", {Result, ResultHi, CarryOut, Zero, Negative, Overflow}, 0);
        rst = 1'b0;
        #1;
        check("post_abort_in_ready", in_ready, 1);
        A        = 8'h21;
        B        = 8'h12;
        ALUOp    = ADD;
        in_valid = 1'b1;
        sb.push_back(model(ADD, 8'h21, 8'h12));
        @(negedge clk);
        in_valid = 1'b0;
        check("post_abort_add_valid", out_valid, 1);
        stray = 0;
        repeat (2 * W) begin
            @(negedge clk);
            stray += int'(out_valid);
        end
        check("no_stray_out_valid", stray, 0);

        // Random mix.
        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            issue(rop, ra, rb);
            if (rop == MUL) idle(W + 1);
        end
        idle(2);

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (sb.size() != 0 && waited < 4 * W) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
